iso_lane_deframer: RTL and testbench
====================================

Name: iso_lane_deframer

Overview:
- Receive-side counterpart of the transmit isochronous lane path (active mapping, blank mapping, idle pattern, SR insertion) for one main-link lane.
- Consumes the descrambled, 8b/10b-decoded lane symbol stream. Locates BS/SR framing and parses the blanking header (VB-ID, Mvid7:0, Maud7:0).
- Separates active pixel bytes, fill-stuffing symbols and secondary-data packets.
- Sits between the lane decoder/descrambler and the RX stream unpacker.

Parameters:
HDR_FIELDS, 3, header fields per copy (VB-ID, Mvid, Maud)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
iso_symbols  in  8  decoded lane symbol
iso_control_sym_flag  in  1  1 = symbol is a K-code
iso_symbol_vld  in  1  symbol qualifier
td_lane_count  in  2  0 = 1 lane, 1 = 2 lanes, 2 = 4 lanes (3 is treated as 4)
pixel_data  out  8  active-video byte
pixel_vld  out  1  pixel_data valid
sec_data  out  8  secondary-data byte
sec_vld  out  1  sec_data valid
sec_sop  out  1  with first sec byte of a packet
sec_eop  out  1  pulse on SE closing a non-empty packet
vb_id  out  8  last captured VB-ID
mvid  out  8  last captured Mvid7:0
maud  out  8  last captured Maud7:0
hdr_vld  out  1  pulse: full header captured and consistent
blank_active  out  1  1 outside active video
scr_reset  out  1  pulse on SR
frame_error  out  1  pulse on protocol violation

Behaviour:
- K-codes decoded on bytes:
  - BS=0xBC, SR=0x1C, BE=0xFB, SS=0x5C, SE=0xFD, FS=0xFE, FE=0xF7.
  - Any other byte with the control flag set is illegal and raises frame_error.
- All outputs are registered, with one-cycle latency from the accepted symbol.
- When iso_symbol_vld=0: state, counters and captured fields hold; all pulses and valids are 0.
- Reset values:
  - State HUNT; all data outputs 0x00.
  - All valids and pulses 0.
  - blank_active=1.
  - hdr_cnt=0, sop_pend=0.
- Header length hdr_len = HDR_FIELDS * copies, where copies = 4 / 2 / 1 for 1 / 2 / 4 lanes, giving 12 / 6 / 3 symbols.
- td_lane_count is sampled on each BS/SR and held for that header.
- BS and SR are equivalent framing starts. SR additionally pulses scr_reset.
- BS/SR received in any state enters HDR with hdr_cnt=0; this is not an error, including mid-packet and mid-fill.
- States:
  - HUNT: data symbols are dropped. Control symbols other than BS/SR are dropped without error.
  - HDR: each data symbol at field index hdr_cnt mod 3 maps to 0 → vb_id, 1 → mvid, 2 → maud.
    - The first copy (hdr_cnt < 3) is written to shadow registers.
    - Later copies are compared against the shadows; any mismatch sets a mismatch flag.
    - On the final header symbol:
      - No mismatch: vb_id, mvid and maud are updated from the shadows, hdr_vld pulses, and the state moves to BLANK.
      - Mismatch: frame_error pulses, outputs keep their old values, and the state moves to HUNT.
    - Any non-BS/SR control symbol in HDR: frame_error, then HUNT.
  - BLANK: data symbols (dummy) are dropped.
    - SS sets sop_pend and moves to SEC.
    - BE moves to ACTIVE.
    - Any other non-framing control symbol: frame_error, then HUNT.
  - SEC: each data symbol drives sec_data with sec_vld=1, and sec_sop=sop_pend; sop_pend then clears.
    - SE moves to BLANK and pulses sec_eop only if at least one byte was emitted. An empty SS-SE pair produces no outputs.
    - Any other non-framing control symbol: frame_error, then HUNT, with no sec_eop.
  - ACTIVE: each data symbol drives pixel_data with pixel_vld=1.
    - FS moves to FILL.
    - Any other non-framing control symbol: frame_error, then HUNT.
  - FILL: data symbols are dropped.
    - FE moves to ACTIVE.
    - Any other non-framing control symbol: frame_error, then HUNT.
- blank_active is 0 in ACTIVE and FILL and 1 otherwise. It is updated in the same cycle as the state register.
- A synchronous rst asserted mid-operation returns every register to its reset value on the next edge. Any partial packet is dropped without sec_eop.

Test Plan:
- 4-lane line (td_lane_count=2): BS, 0x00, 0x12, 0x34, BE, data 0xA0..0xA7, BS → hdr_vld once with vb_id=0x00, mvid=0x12, maud=0x34; 8 pixel_vld carrying 0xA0..0xA7; blank_active 1→0→1.
- 1-lane header (td_lane_count=0): SR followed by 4 identical copies of 0x01,0x55,0x66 → scr_reset pulse and hdr_vld after the 12th symbol. Repeat with copy 3 Mvid=0x56 → frame_error, no hdr_vld, state HUNT, vb_id/mvid/maud unchanged.
- Secondary packet in BLANK: SS, 0x11, 0x22, 0x33, SE → sec_vld x3 with sec_sop on 0x11 and sec_eop one cycle after 0x33. An empty SS, SE → no sec outputs.
- Fill: ACTIVE data 0x10, FS, 0x00 x3, FE, 0x20 → pixel_vld only for 0x10 and 0x20, no error. A BS during FILL → HDR, no frame_error.
- Illegal K 0x7C in ACTIVE → frame_error one cycle, pixel output stops, data ignored until the next BS. Toggle iso_symbol_vld low mid-SEC → no output and state held.
- Assert rst in the middle of SEC → next cycle all outputs are reset values, no sec_eop.

Source files
------------

// File: rtl/iso_lane_deframer.sv
// iso_lane_deframer: receive-side framing parser for one isochronous main-link lane.
// Finds BS/SR framing, captures the replicated blanking header (VB-ID, Mvid, Maud),
// and splits the symbol stream into active pixels, fill stuffing and secondary packets.
module iso_lane_deframer #(
  parameter int HDR_FIELDS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] iso_symbols,
  input  logic       iso_control_sym_flag,
  input  logic       iso_symbol_vld,
  input  logic [1:0] td_lane_count,
  output logic [7:0] pixel_data,
  output logic       pixel_vld,
  output logic [7:0] sec_data,
  output logic       sec_vld,
  output logic       sec_sop,
  output logic       sec_eop,
  output logic [7:0] vb_id,
  output logic [7:0] mvid,
  output logic [7:0] maud,
  output logic       hdr_vld,
  output logic       blank_active,
  output logic       scr_reset,
  output logic       frame_error
);

  localparam int CW = $clog2(4 * HDR_FIELDS + 1);
  localparam logic [1:0] FLD_LAST = 2'(HDR_FIELDS - 1);

  localparam logic [7:0] K_BS = 8'hBC;
  localparam logic [7:0] K_SR = 8'h1C;
  localparam logic [7:0] K_BE = 8'hFB;
  localparam logic [7:0] K_SS = 8'h5C;
  localparam logic [7:0] K_SE = 8'hFD;
  localparam logic [7:0] K_FS = 8'hFE;
  localparam logic [7:0] K_FE = 8'hF7;

  typedef enum logic [2:0] {
    S_HUNT,
    S_HDR,
    S_BLANK,
    S_SEC,
    S_ACTIVE,
    S_FILL
  } state_t;

  state_t        state_q;
  logic [CW-1:0] hdr_cnt_q;
  logic [CW-1:0] hdr_len_q;
  logic [CW-1:0] hdr_len_d;
  logic [1:0]    fld_q;
  logic          mismatch_q;
  logic          sop_pend_q;
  logic [7:0]    sh_vb_q, sh_mvid_q, sh_maud_q;
  logic [7:0]    sh_sel_d;

  logic [7:0] pixel_data_q, sec_data_q, vb_id_q, mvid_q, maud_q;
  logic       pixel_vld_q, sec_vld_q, sec_sop_q, sec_eop_q, hdr_vld_q;
  logic       blank_active_q, scr_reset_q, frame_error_q;

  logic is_k, is_frame, sym_mismatch, hdr_last;

  assign is_k     = iso_control_sym_flag;
  assign is_frame = is_k && ((iso_symbols == K_BS) || (iso_symbols == K_SR));
  assign hdr_last = (hdr_cnt_q == hdr_len_q - CW'(1));

  // Header length for the lane count presented alongside the framing symbol.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    hdr_len_d = CW'(HDR_FIELDS);
    case (td_lane_count)
      2'd0:    hdr_len_d = CW'(4 * HDR_FIELDS);
      2'd1:    hdr_len_d = CW'(2 * HDR_FIELDS);
      default: hdr_len_d = CW'(HDR_FIELDS);
    endcase
  end

  // Shadow field matching the current header position, used to check later copies.
  always_comb begin
    sh_sel_d = sh_maud_q;
    case (fld_q)
      2'd0:    sh_sel_d = sh_vb_q;
      2'd1:    sh_sel_d = sh_mvid_q;
      default: sh_sel_d = sh_maud_q;
    endcase
  end

  assign sym_mismatch = (hdr_cnt_q >= CW'(HDR_FIELDS)) && (iso_symbols != sh_sel_d);

  // Framing state machine with all outputs registered one cycle after the accepted symbol.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_HUNT;
      hdr_cnt_q      <= '0;
      hdr_len_q      <= CW'(HDR_FIELDS);
      fld_q          <= '0;
      mismatch_q     <= 1'b0;
      sop_pend_q     <= 1'b0;
      sh_vb_q        <= '0;
      sh_mvid_q      <= '0;
      sh_maud_q      <= '0;
      pixel_data_q   <= '0;
      pixel_vld_q    <= 1'b0;
      sec_data_q     <= '0;
      sec_vld_q      <= 1'b0;
      sec_sop_q      <= 1'b0;
      sec_eop_q      <= 1'b0;
      vb_id_q        <= '0;
      mvid_q         <= '0;
      maud_q         <= '0;
      hdr_vld_q      <= 1'b0;
      blank_active_q <= 1'b1;
      scr_reset_q    <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      pixel_vld_q   <= 1'b0;
      sec_vld_q     <= 1'b0;
      sec_sop_q     <= 1'b0;
      sec_eop_q     <= 1'b0;
      hdr_vld_q     <= 1'b0;
      scr_reset_q   <= 1'b0;
      frame_error_q <= 1'b0;

      if (iso_symbol_vld) begin
        if (is_frame) begin
          // BS/SR restarts header capture from any state, never an error.
          state_q        <= S_HDR;
          hdr_cnt_q      <= '0;
          fld_q          <= '0;
          mismatch_q     <= 1'b0;
          hdr_len_q      <= hdr_len_d;
          sop_pend_q     <= 1'b0;
          blank_active_q <= 1'b1;
          scr_reset_q    <= (iso_symbols == K_SR);
        end else begin
          case (state_q)
            S_HUNT: begin
              // Everything but framing is dropped silently while hunting.
            end

            S_HDR: begin
              if (is_k) begin
                frame_error_q <= 1'b1;
                state_q       <= S_HUNT;
              end else begin
                if (hdr_cnt_q < CW'(HDR_FIELDS)) begin
                  case (fld_q)
                    2'd0:    sh_vb_q   <= iso_symbols;
                    2'd1:    sh_mvid_q <= iso_symbols;
                    default: sh_maud_q <= iso_symbols;
                  endcase
                end
                if (hdr_last) begin
                  if (mismatch_q || sym_mismatch) begin
                    frame_error_q <= 1'b1;
                    state_q       <= S_HUNT;
                  end else begin
                    // The last symbol is always the Maud field and equals its shadow when consistent.
                    vb_id_q   <= sh_vb_q;
                    mvid_q    <= sh_mvid_q;
                    maud_q    <= iso_symbols;
                    hdr_vld_q <= 1'b1;
                    state_q   <= S_BLANK;
                  end
                end else begin
                  hdr_cnt_q  <= hdr_cnt_q + CW'(1);
                  fld_q      <= (fld_q == FLD_LAST) ? 2'd0 : fld_q + 2'd1;
                  mismatch_q <= mismatch_q | sym_mismatch;
                end
              end
            end

            S_BLANK: begin
              if (is_k) begin
                if (iso_symbols == K_SS) begin
                  sop_pend_q <= 1'b1;
                  state_q    <= S_SEC;
                end else if (iso_symbols == K_BE) begin
                  state_q        <= S_ACTIVE;
                  blank_active_q <= 1'b0;
                end else begin
                  frame_error_q <= 1'b1;
                  state_q       <= S_HUNT;
                end
              end
            end

            S_SEC: begin
              if (!is_k) begin
                sec_data_q <= iso_symbols;
                sec_vld_q  <= 1'b1;
                sec_sop_q  <= sop_pend_q;
                sop_pend_q <= 1'b0;
              end else if (iso_symbols == K_SE) begin
                // sop_pend still set means nothing was emitted: empty packet, no eop.
                sec_eop_q  <= ~sop_pend_q;
                sop_pend_q <= 1'b0;
                state_q    <= S_BLANK;
              end else begin
                frame_error_q <= 1'b1;
                sop_pend_q    <= 1'b0;
                state_q       <= S_HUNT;
              end
            end

            S_ACTIVE: begin
              if (!is_k) begin
                pixel_data_q <= iso_symbols;
                pixel_vld_q  <= 1'b1;
              end else if (iso_symbols == K_FS) begin
                state_q <= S_FILL;
              end else begin
                frame_error_q  <= 1'b1;
                state_q        <= S_HUNT;
                blank_active_q <= 1'b1;
              end
            end

            S_FILL: begin
              if (is_k) begin
                if (iso_symbols == K_FE) begin
                  state_q <= S_ACTIVE;
                end else begin
                  frame_error_q  <= 1'b1;
                  state_q        <= S_HUNT;
                  blank_active_q <= 1'b1;
                end
              end
            end

            default: begin
              state_q        <= S_HUNT;
              blank_active_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign pixel_data   = pixel_data_q;
  assign pixel_vld    = pixel_vld_q;
  assign sec_data     = sec_data_q;
  assign sec_vld      = sec_vld_q;
  assign sec_sop      = sec_sop_q;
  assign sec_eop      = sec_eop_q;
  assign vb_id        = vb_id_q;
  assign mvid         = mvid_q;
  assign maud         = maud_q;
  assign hdr_vld      = hdr_vld_q;
  assign blank_active = blank_active_q;
  assign scr_reset    = scr_reset_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_iso_lane_deframer.sv
// Testbench for iso_lane_deframer: directed line scenarios plus randomized lines,
// a frame-level reference model feeding expectation queues, and a monitor that drains them.
module tb_iso_lane_deframer;

  localparam logic [7:0] K_BS  = 8'hBC;
  localparam logic [7:0] K_SR  = 8'h1C;
  localparam logic [7:0] K_BE  = 8'hFB;
  localparam logic [7:0] K_SS  = 8'h5C;
  localparam logic [7:0] K_SE  = 8'hFD;
  localparam logic [7:0] K_FS  = 8'hFE;
  localparam logic [7:0] K_FE  = 8'hF7;
  localparam logic [7:0] K_BAD = 8'h7C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] iso_symbols = 8'h00;
  logic       iso_control_sym_flag = 1'b0;
  logic       iso_symbol_vld = 1'b0;
  logic [1:0] td_lane_count = 2'd2;
  logic [7:0] pixel_data, sec_data, vb_id, mvid, maud;
  logic       pixel_vld, sec_vld, sec_sop, sec_eop, hdr_vld;
  logic       blank_active, scr_reset, frame_error;

  iso_lane_deframer #(.HDR_FIELDS(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .iso_symbols          (iso_symbols),
    .iso_control_sym_flag (iso_control_sym_flag),
    .iso_symbol_vld       (iso_symbol_vld),
    .td_lane_count        (td_lane_count),
    .pixel_data           (pixel_data),
    .pixel_vld            (pixel_vld),
    .sec_data             (sec_data),
    .sec_vld              (sec_vld),
    .sec_sop              (sec_sop),
    .sec_eop              (sec_eop),
    .vb_id                (vb_id),
    .mvid                 (mvid),
    .maud                 (maud),
    .hdr_vld              (hdr_vld),
    .blank_active         (blank_active),
    .scr_reset            (scr_reset),
    .frame_error          (frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (frame-level view of the lane) ----------------
  typedef enum {M_HUNT, M_HDR, M_BLANK, M_SEC, M_ACT, M_FILL} mode_e;

  mode_e      m_mode = M_HUNT;
  logic [7:0] m_hdr[$];
  int         m_need = 0;
  int         m_sec_len = 0;
  bit         m_blank = 1'b1;

  logic [7:0]  pix_q[$];
  logic [8:0]  sec_q[$];   // {sop, data}
  int          eop_q[$];   // expected packet length at eop
  logic [23:0] hdr_q[$];   // {vb_id, mvid, maud}
  bit          blank_q[$];
  int          exp_scr = 0;
  int          exp_err = 0;

  function automatic void set_blank(bit v);
    if (v != m_blank) blank_q.push_back(v);
    m_blank = v;
  endfunction

  function automatic void m_error();
    exp_err++;
    m_mode = M_HUNT;
    set_blank(1'b1);
  endfunction

  function automatic void model_reset();
    m_mode = M_HUNT;
    set_blank(1'b1);
    m_hdr.delete();
    m_sec_len = 0;
  endfunction

  function automatic void model_sym(logic [7:0] s, bit k, logic [1:0] lanes);
    bit ok;
    if (k && (s == K_BS || s == K_SR)) begin
      if (s == K_SR) exp_scr++;
      m_mode = M_HDR;
      m_hdr.delete();
      m_need = 3 * ((lanes == 2'd0) ? 4 : (lanes == 2'd1) ? 2 : 1);
      set_blank(1'b1);
      return;
    end
    case (m_mode)
      M_HUNT: ;
      M_HDR: begin
        if (k) m_error();
        else begin
          m_hdr.push_back(s);
          if (m_hdr.size() == m_need) begin
            ok = 1'b1;
            for (int i = 0; i < m_need; i++)
              if (m_hdr[i] != m_hdr[i % 3]) ok = 1'b0;
            if (ok) begin
              hdr_q.push_back({m_hdr[0], m_hdr[1], m_hdr[2]});
              m_mode = M_BLANK;
            end else m_error();
          end
        end
      end
      M_BLANK: begin
        if (k) begin
          if (s == K_SS) begin m_mode = M_SEC; m_sec_len = 0; end
          else if (s == K_BE) begin m_mode = M_ACT; set_blank(1'b0); end
          else m_error();
        end
      end
      M_SEC: begin
        if (!k) begin
          sec_q.push_back({(m_sec_len == 0), s});
          m_sec_len++;
        end else if (s == K_SE) begin
          if (m_sec_len > 0) eop_q.push_back(m_sec_len);
          m_mode = M_BLANK;
        end else m_error();
      end
      M_ACT: begin
        if (!k) pix_q.push_back(s);
        else if (s == K_FS) m_mode = M_FILL;
        else m_error();
      end
      M_FILL: begin
        if (k) begin
          if (s == K_FE) m_mode = M_ACT;
          else m_error();
        end
      end
      default: ;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] s, input bit k);
    iso_symbols          = s;
    iso_control_sym_flag = k;
    iso_symbol_vld       = 1'b1;
    model_sym(s, k, td_lane_count);
    @(posedge clk);
    #1;
    iso_symbol_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      iso_symbols          = 8'($urandom);
      iso_control_sym_flag = 1'($urandom);
      iso_symbol_vld       = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
  endtask

  logic [7:0] k_list[8];

  task automatic rand_line();
    logic [1:0] lc;
    int         copies;
    logic [7:0] f[3];
    logic [7:0] v;
    lc = 2'($urandom_range(0, 3));
    td_lane_count = lc;
    send(($urandom_range(0, 1) != 0) ? K_SR : K_BS, 1'b1);
    td_lane_count = 2'($urandom_range(0, 3));  // must be ignored until the next framing symbol
    copies = (lc == 2'd0) ? 4 : (lc == 2'd1) ? 2 : 1;
    for (int i = 0; i < 3; i++) f[i] = 8'($urandom);
    for (int c = 0; c < copies; c++)
      for (int i = 0; i < 3; i++) begin
        v = f[i];
        if ($urandom_range(0, 24) == 0) v = v ^ 8'h01;
        send(v, 1'b0);
        maybe_gap();
      end
    for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
      send(8'($urandom), 1'b0);
      send(K_SS, 1'b1);
      for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
        send(8'($urandom), 1'b0);
        maybe_gap();
      end
      send(K_SE, 1'b1);
    end
    if ($urandom_range(0, 15) == 0) send(k_list[$urandom_range(0, 7)], 1'b1);
    else send(K_BE, 1'b1);
    for (int n = 0; n < int'($urandom_range(0, 10)); n++) begin
      if ($urandom_range(0, 6) == 0) begin
        send(K_FS, 1'b1);
        repeat ($urandom_range(0, 3)) send(8'($urandom), 1'b0);
        send(K_FE, 1'b1);
      end
      send(8'($urandom), 1'b0);
      maybe_gap();
    end
    if ($urandom_range(0, 12) == 0) send(k_list[$urandom_range(0, 7)], 1'b1);
  endtask

  // ---------------- monitor ----------------
  bit          mon_en = 1'b0;
  bit          prev_blank;
  bit          rst_at_edge;
  logic [23:0] mon_last = 24'h0;
  logic [23:0] hdr_exp;
  int          mon_sec_cnt = 0;
  int          seen_scr = 0;
  int          seen_err = 0;

  initial begin
    wait (mon_en);
    prev_blank = blank_active;
    forever begin
      @(posedge clk);
      rst_at_edge = rst;
      @(negedge clk);
      if (rst_at_edge) begin
        mon_last    = 24'h0;
        mon_sec_cnt = 0;
      end
      if (pixel_vld) begin
        if (pix_q.size() == 0) check("pixel_unexpected", {24'h0, pixel_data}, 32'hFFFF_FFFF);
        else check("pixel_data", {24'h0, pixel_data}, {24'h0, pix_q.pop_front()});
      end
      if (sec_vld) begin
        mon_sec_cnt = sec_sop ? 1 : mon_sec_cnt + 1;
        if (sec_q.size() == 0) check("sec_unexpected", {23'h0, sec_sop, sec_data}, 32'hFFFF_FFFF);
        else check("sec_sop_data", {23'h0, sec_sop, sec_data}, {23'h0, sec_q.pop_front()});
      end
      if (sec_eop) begin
        if (eop_q.size() == 0) check("sec_eop_unexpected", 32'(mon_sec_cnt), 32'hFFFF_FFFF);
        else check("sec_eop_pkt_len", 32'(mon_sec_cnt), 32'(eop_q.pop_front()));
      end
      if (hdr_vld) begin
        if (hdr_q.size() == 0) check("hdr_unexpected", {8'h0, vb_id, mvid, maud}, 32'hFFFF_FFFF);
        else begin
          hdr_exp = hdr_q.pop_front();
          check("hdr_fields", {8'h0, vb_id, mvid, maud}, {8'h0, hdr_exp});
          mon_last = hdr_exp;
        end
      end
      if (frame_error) begin
        seen_err++;
        check("fields_held_on_error", {8'h0, vb_id, mvid, maud}, {8'h0, mon_last});
      end
      if (scr_reset) seen_scr++;
      if (blank_active !== prev_blank) begin
        if (blank_q.size() == 0) check("blank_unexpected", {31'h0, blank_active}, 32'hFFFF_FFFF);
        else check("blank_active", {31'h0, blank_active}, {31'h0, blank_q.pop_front()});
        prev_blank = blank_active;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valids"}, {25'h0, pixel_vld, sec_vld, sec_sop, sec_eop, hdr_vld, scr_reset, frame_error}, 32'h0);
    check({tag, "_data"}, {pixel_data, sec_data, 16'h0}, 32'h0);
    check({tag, "_fields"}, {8'h0, vb_id, mvid, maud}, 32'h0);
    check({tag, "_blank"}, {31'h0, blank_active}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    k_list = '{K_BS, K_SR, K_BE, K_SS, K_SE, K_FS, K_FE, K_BAD};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // 4-lane line with active video closed by the next BS.
    td_lane_count = 2'd2;
    send(K_BS, 1'b1);
    send(8'h00, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0);
    send(K_BE, 1'b1);
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 1'b0);
    send(K_BS, 1'b1);

    // 1-lane header via SR, consistent copies then one corrupted Mvid copy.
    td_lane_count = 2'd0;
    send(K_SR, 1'b1);
    for (int c = 0; c < 4; c++) begin send(8'h01, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0); end
    send(K_SR, 1'b1);
    for (int c = 0; c < 4; c++) begin
      send(8'h01, 1'b0); send((c == 2) ? 8'h56 : 8'h55, 1'b0); send(8'h66, 1'b0);
    end
    send(8'h99, 1'b0);  // dropped in HUNT

    // Secondary packet, empty packet, valid gap inside a packet, fill, BS during fill.
    td_lane_count = 2'd2;
    send(K_BS, 1'b1);
    send(8'h07, 1'b0); send(8'h08, 1'b0); send(8'h09, 1'b0);
    send(K_SS, 1'b1); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(K_SE, 1'b1);
    send(K_SS, 1'b1); send(K_SE, 1'b1);
    send(K_SS, 1'b1); send(8'h44, 1'b0); idle(3); send(8'h55, 1'b0); send(K_SE, 1'b1);
    send(K_BE, 1'b1);
    send(8'h10, 1'b0); send(K_FS, 1'b1);
    repeat (3) send(8'h00, 1'b0);
    send(K_FE, 1'b1); send(8'h20, 1'b0);
    send(K_FS, 1'b1); send(8'h00, 1'b0);
    send(K_BS, 1'b1);
    send(8'h0A, 1'b0); send(8'h0B, 1'b0); send(8'h0C, 1'b0);

    // Illegal K in ACTIVE, then data is ignored until the next BS.
    send(K_BE, 1'b1); send(8'h31, 1'b0);
    send(K_BAD, 1'b1);
    send(8'h32, 1'b0); send(8'h33, 1'b0);

    // Reset in the middle of a secondary packet.
    send(K_BS, 1'b1);
    send(8'h0D, 1'b0); send(8'h0E, 1'b0); send(8'h0F, 1'b0);
    send(K_SS, 1'b1); send(8'h61, 1'b0);
    rst = 1'b1;
    iso_symbols = 8'h62; iso_control_sym_flag = 1'b0; iso_symbol_vld = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("midsec_reset");
    rst = 1'b0;
    iso_symbol_vld = 1'b0;
    send(K_SE, 1'b1);  // ignored in HUNT: no eop
    idle(2);

    // Randomized lines.
    for (int l = 0; l < 80; l++) rand_line();

    idle(6);
    check("pixel_q_drained", 32'(pix_q.size()), 32'h0);
    check("sec_q_drained", 32'(sec_q.size()), 32'h0);
    check("eop_q_drained", 32'(eop_q.size()), 32'h0);
    check("hdr_q_drained", 32'(hdr_q.size()), 32'h0);
    check("blank_q_drained", 32'(blank_q.size()), 32'h0);
    check("scr_reset_count", 32'(seen_scr), 32'(exp_scr));
    check("frame_error_count", 32'(seen_err), 32'(exp_err));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
